// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: inter-stage pipeline register with valid/ready handshake,
// flush, an optional skid entry and a saturating stall-cycle counter.
// SKID=1 gives a two-entry elastic stage whose in_ready depends only on state.
// SKID=0 gives a single-entry stage whose in_ready passes out_ready through.
module pipe_skid_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DATA_W-1:0] main_r;
    logic [DATA_W-1:0] main_nxt_s;
    logic [DATA_W-1:0] skid_r;
    logic [DATA_W-1:0] skid_nxt_s;
    logic [CNT_W-1:0]  stall_r;
    logic              out_valid_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              emit_s;

    assign out_valid_s = (state_r != ST_EMPTY);
    assign accept_s    = in_valid & in_ready_s;
    assign emit_s      = out_valid_s & out_ready;

    // The skid variant decouples in_ready from out_ready; the single-entry
    // variant lets a draining entry make room in the same cycle.
    generate
        if (SKID != 32'd0) begin : g_skid
            assign in_ready_s = (state_r != ST_TWO);
        end else begin : g_pass
            assign in_ready_s = ~out_valid_s | out_ready;
        end
    endgenerate

    // Occupancy next-state and payload next values; flush overrides everything
    // but leaves the payload registers untouched.
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        skid_nxt_s  = skid_r;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = ST_ONE;
                        main_nxt_s  = in_data;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && emit_s) begin
                        state_nxt_s = ST_ONE;
                        main_nxt_s  = in_data;
                    end else if (accept_s) begin
                        // Only the skid variant can accept while holding an
                        // un-emitted entry; the other branch is defensive.
                        if (SKID != 32'd0) begin
                            state_nxt_s = ST_TWO;
                            skid_nxt_s  = in_data;
                        end else begin
                            state_nxt_s = ST_ONE;
                            main_nxt_s  = in_data;
                        end
                    end else if (emit_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (emit_s) begin
                        state_nxt_s = ST_ONE;
                        main_nxt_s  = skid_r;
                    end else begin
                        state_nxt_s = ST_TWO;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state and payload registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_EMPTY;
            main_r  <= {DATA_W{1'b0}};
            skid_r  <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            main_r  <= main_nxt_s;
            skid_r  <= skid_nxt_s;
        end
    end

    // Saturating count of cycles where the held entry is refused downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_r <= {CNT_W{1'b0}};
        end else if (out_valid_s && !out_ready && (stall_r != {CNT_W{1'b1}})) begin
            stall_r <= stall_r + CNT_W'(1);
        end else begin
            stall_r <= stall_r;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_s;
    assign out_data     = main_r;
    assign stall_cycles = stall_r;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg. Three instances share one stimulus:
// SKID=1 (32-bit counter), SKID=0, and SKID=1 with a 3-bit counter. Each is
// tracked by a queue-based reference model; a directed table adds hand
// computed expectations for the SKID=1 instance.
module tb_pipe_skid_reg;

    typedef logic [15:0] word_t;

    typedef struct {
        logic        iv;
        word_t       id;
        logic        ordy;
        logic        fl;
        logic        rst;
        logic        ev;
        word_t       ed;
        logic        er;
        logic [31:0] es;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    word_t       in_data;
    logic        flush;
    logic        out_ready;

    logic        dv [3];
    logic        dr [3];
    word_t       dd [3];
    logic [31:0] stall0;
    logic [31:0] stall1;
    logic [2:0]  stall2;
    logic [31:0] ds [3];

    word_t       mq [3][$];
    word_t       mlast [3];
    logic [31:0] mstall [3];
    logic [31:0] mmax [3];
    logic        m_acc [3];
    logic        m_emt [3];

    int          n_checks;
    int          n_errors;
    vec_t        tbl [18];

    assign ds[0] = stall0;
    assign ds[1] = stall1;
    assign ds[2] = {29'd0, stall2};

    pipe_skid_reg #(.DATA_W(16), .SKID(1), .CNT_W(32)) u_dut_s1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(dr[0]),
        .in_data(in_data), .flush(flush), .out_valid(dv[0]),
        .out_ready(out_ready), .out_data(dd[0]), .stall_cycles(stall0)
    );

    pipe_skid_reg #(.DATA_W(16), .SKID(0), .CNT_W(32)) u_dut_s0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(dr[1]),
        .in_data(in_data), .flush(flush), .out_valid(dv[1]),
        .out_ready(out_ready), .out_data(dd[1]), .stall_cycles(stall1)
    );

    pipe_skid_reg #(.DATA_W(16), .SKID(1), .CNT_W(3)) u_dut_c3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(dr[2]),
        .in_data(in_data), .flush(flush), .out_valid(dv[2]),
        .out_ready(out_ready), .out_data(dd[2]), .stall_cycles(stall2)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then compare every instance to its model.
    task automatic drive(input logic iv, input word_t id, input logic ordy,
                         input logic fl, input logic rst, input bit chk);
        logic  er;
        word_t ed;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) er = (mq[k].size() == 0) || ordy;
            else        er = (mq[k].size() < 2);
            ed = (mq[k].size() != 0) ? mq[k][0] : mlast[k];
            if (chk) begin
                check($sformatf("out_valid[%0d]", k), {31'd0, dv[k]}, {31'd0, (mq[k].size() != 0)});
                check($sformatf("out_data[%0d]", k), {16'd0, dd[k]}, {16'd0, ed});
                check($sformatf("in_ready[%0d]", k), {31'd0, dr[k]}, {31'd0, er});
                check($sformatf("stall_cycles[%0d]", k), ds[k], mstall[k]);
            end
            m_acc[k] = iv && er;
            m_emt[k] = (mq[k].size() != 0) && ordy;
        end
    endtask

    // Clock edge, then move each model on by the rules of the stage.
    task automatic advance();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                mq[k].delete();
                mlast[k]  = 16'd0;
                mstall[k] = 32'd0;
            end else begin
                if ((mq[k].size() != 0) && !out_ready && (mstall[k] != mmax[k]))
                    mstall[k] = mstall[k] + 32'd1;
                if (flush) begin
                    mq[k].delete();
                end else begin
                    if (m_emt[k]) void'(mq[k].pop_front());
                    if (m_acc[k]) mq[k].push_back(in_data);
                end
                if (mq[k].size() != 0) mlast[k] = mq[k][0];
            end
        end
        @(negedge clk);
    endtask

    task automatic cycle(input logic iv, input word_t id, input logic ordy,
                         input logic fl, input logic rst);
        drive(iv, id, ordy, fl, rst, 1'b1);
        advance();
    endtask

    function automatic vec_t mk(input logic iv, input word_t id, input logic ordy,
                                input logic fl, input logic rst, input logic ev,
                                input word_t ed, input logic er, input logic [31:0] es);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl; v.rst = rst;
        v.ev = ev; v.ed = ed; v.er = er; v.es = es;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        mmax[0] = 32'hFFFF_FFFF;
        mmax[1] = 32'hFFFF_FFFF;
        mmax[2] = 32'd7;
        for (int k = 0; k < 3; k++) begin
            mlast[k]  = 16'd0;
            mstall[k] = 32'd0;
        end
        in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b0; flush = 1'b0; reset = 1'b1;

        // Directed table for the SKID=1 instance: back-pressure into skid,
        // flush while full with a concurrent input, reset while full.
        //            iv    id      ordy  fl    rst   ev    ed      er    es
        tbl[0]  = mk(1'b1, 16'hA, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 32'd0);
        tbl[1]  = mk(1'b1, 16'hB, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA, 1'b1, 32'd0);
        tbl[2]  = mk(1'b1, 16'hC, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA, 1'b0, 32'd1);
        tbl[3]  = mk(1'b1, 16'hC, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA, 1'b0, 32'd2);
        tbl[4]  = mk(1'b1, 16'hC, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA, 1'b0, 32'd3);
        tbl[5]  = mk(1'b1, 16'hC, 1'b1, 1'b0, 1'b0, 1'b1, 16'hB, 1'b1, 32'd3);
        tbl[6]  = mk(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hC, 1'b1, 32'd3);
        tbl[7]  = mk(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hC, 1'b1, 32'd3);
        tbl[8]  = mk(1'b1, 16'h1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hC, 1'b1, 32'd3);
        tbl[9]  = mk(1'b1, 16'h2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1, 1'b1, 32'd3);
        tbl[10] = mk(1'b1, 16'hD, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1, 1'b0, 32'd4);
        tbl[11] = mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1, 1'b1, 32'd5);
        tbl[12] = mk(1'b1, 16'hE, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1, 1'b1, 32'd5);
        tbl[13] = mk(1'b1, 16'hF, 1'b0, 1'b0, 1'b0, 1'b1, 16'hE, 1'b1, 32'd5);
        tbl[14] = mk(1'b1, 16'h7, 1'b0, 1'b0, 1'b1, 1'b1, 16'hE, 1'b0, 32'd6);
        tbl[15] = mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 32'd0);
        tbl[16] = mk(1'b1, 16'h9, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 32'd0);
        tbl[17] = mk(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h9, 1'b1, 32'd0);

        @(negedge clk);
        drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        advance();
        drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        advance();

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl, tbl[i].rst, 1'b1);
            check($sformatf("tbl%0d_valid", i), {31'd0, dv[0]}, {31'd0, tbl[i].ev});
            check($sformatf("tbl%0d_data", i), {16'd0, dd[0]}, {16'd0, tbl[i].ed});
            check($sformatf("tbl%0d_ready", i), {31'd0, dr[0]}, {31'd0, tbl[i].er});
            check($sformatf("tbl%0d_stall", i), ds[0], tbl[i].es);
            advance();
        end

        // Full-rate stream 1..8 after reset: one word per cycle, no stalls.
        cycle(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, word_t'(i), 1'b1, 1'b0, 1'b0);
            check($sformatf("stream_data%0d", i), {16'd0, dd[0]}, i);
            check($sformatf("stream_s0_data%0d", i), {16'd0, dd[1]}, i);
        end
        cycle(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        check("stream_stall", ds[0], 32'd0);

        // Ten refused cycles with an entry held: 3-bit counter stops at 7.
        cycle(1'b1, 16'h55, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_cnt3", ds[2], 32'd7);
        check("sat_cnt32", ds[0], 32'd10);
        advance();

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), word_t'($urandom),
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 299) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised inter-stage pipeline register with valid/ready handshake, flush, and an optional skid entry. It generalises the plain reset-to-zero stage register (e.g. MEM/WB) by carrying an arbitrary-width payload, supporting back-pressure without dropping data, and counting stall cycles for performance analysis. It sits between any two pipeline stages. Upstream drives `in_*`; downstream consumes `out_*`.

## Interface
- `DATA_W`, default 64: payload width in bits; packed stage struct width.
- `SKID`, default 1: 1 = two-entry elastic stage (main + skid); 0 = single-entry stage with combinational ready pass-through.
- `CNT_W`, default 32: width of the stall counter.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `flush`  in  1  discard all held and incoming entries.
- `out_valid`  out  1  main entry valid.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  DATA_W  main entry payload.
- `stall_cycles`  out  CNT_W  saturating count of cycles with `out_valid && !out_ready`.

## Operation
- Accept: `in_valid && in_ready`. Emit: `out_valid && out_ready`.
- Occupancy state:
  - EMPTY: no entries held.
  - ONE: main entry holds data.
  - TWO: main and skid entries hold data. TWO is only reachable when SKID=1.
- Transitions (SKID=1), evaluated when `flush`=0:
  - EMPTY: accept -> ONE, main<=in_data.
  - ONE: accept only -> TWO, skid<=in_data. Emit only -> EMPTY. Accept+emit -> ONE, main<=in_data. Neither -> ONE, hold.
  - TWO: emit -> ONE, main<=skid. No emit -> hold.
- SKID=1: `in_ready = (state != TWO)`. It is a registered function of state and has no combinational path from `out_ready`.
- SKID=0:
  - `in_ready = !out_valid || out_ready`.
  - States are EMPTY and ONE only.
  - Accept loads main. Emit without accept -> EMPTY.
- Flush has highest priority:
  - Next state is EMPTY.
  - Any accept in the same cycle is discarded.
  - Payload registers keep their previous contents.
  - `stall_cycles` is unaffected by flush.
- `out_valid = (state != EMPTY)`. `out_data` = main register.
- Payload ordering is strictly FIFO. No payload is duplicated or dropped unless `flush` is asserted.
- `stall_cycles`:
  - Increments by 1 in each cycle where `out_valid && !out_ready`.
  - Saturates at 2^CNT_W−1.
  - Cleared only by `reset`.

## Timing
- Reset, synchronous:
  - state=EMPTY, `out_valid`=0, main=skid=0, `out_data`=0, `stall_cycles`=0.
  - `in_ready`=1 in the cycle after reset is sampled.
- Latency: payload accepted at edge N appears on `out_data` with `out_valid`=1 after edge N, when the stage was EMPTY or emitting.
- Throughput: 1 payload/cycle when `out_ready`=1 continuously, for both SKID values.
- SKID=1 back-pressure:
  - When `out_ready` drops while full-rate input continues, one extra payload is absorbed into skid.
  - `in_ready` deasserts the following cycle.
- Flush and reset asserted in the same cycle: reset wins; both yield EMPTY.
- Reset asserted mid-operation: held entries are lost and the counter is zeroed.
- `out_data` is defined (last main value) even when `out_valid`=0.

## Test plan
- Reset then stream 0x1..0x8 with `out_ready`=1 -> `out_data` sequence 0x1..0x8, one per cycle starting 1 cycle after first accept; `stall_cycles`=0.
- SKID=1, stream 0xA,0xB,0xC, `out_ready`=0 after 0xA becomes valid -> 0xB goes to skid and `in_ready`=0. 0xC is held upstream. After `out_ready`=1, output is 0xA,0xB,0xC in order, and `stall_cycles` equals the number of stalled cycles.
- SKID=0, same stimulus -> `in_ready` follows `out_ready` combinationally; no skid capture; order 0xA,0xB,0xC.
- In state TWO, assert `flush` together with `in_valid`=1 (0xD) -> next cycle `out_valid`=0 and `in_ready`=1; 0xD is never emitted.
- CNT_W=3, hold `out_valid`=1 and `out_ready`=0 for 10 cycles -> `stall_cycles` saturates at 7.
- Assert `reset` while in state TWO with `stall_cycles`=5 -> next cycle `out_valid`=0, `out_data`=0, `stall_cycles`=0, `in_ready`=1.
